// File: rtl/sysid_checker_if.sv
// Signal bundle between the sysid checker, the Qsys system-ID slave it reads,
// and the status logic that starts checks and consumes the result.
interface sysid_checker_if;
    logic        start;
    logic        sys_address;
    logic [31:0] sys_readdata;
    logic        busy;
    logic        done;
    logic        match;
    logic        id_ok;
    logic        ts_ok;
    logic [31:0] id_value;
    logic [31:0] ts_value;
    logic [3:0]  attempts;

    modport master (
        input  start, sys_readdata,
        output sys_address, busy, done, match, id_ok, ts_ok, id_value, ts_value, attempts
    );
    modport slave (
        output start, sys_readdata,
        input  sys_address, busy, done, match, id_ok, ts_ok, id_value, ts_value, attempts
    );
endinterface

// File: rtl/sysid_checker.sv
// Boot-time sysid integrity check: reads ID and timestamp words from the sysid
// slave, compares them to build-time values, retries on mismatch, reports once.
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID  = 32'd0,
    parameter logic [31:0] EXPECTED_TS  = 32'd1516688433,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned RETRY_MAX    = 3,
    parameter bit          AUTO_START   = 1'b1
) (
    input  logic            clock,
    input  logic            reset,
    sysid_checker_if.master bus
);
    typedef enum logic [1:0] {IDLE, RD_ID, RD_TS, CMP} state_t;

    typedef struct packed {
        logic        match;
        logic        id_ok;
        logic        ts_ok;
        logic [31:0] id_value;
        logic [31:0] ts_value;
        logic [3:0]  attempts;
    } result_t;

    localparam logic [2:0] WAIT_LAST    = 3'(READ_LATENCY);
    localparam logic [3:0] LAST_ATTEMPT = 4'(RETRY_MAX + 1);

    state_t      state, state_nxt;
    logic [2:0]  wait_cnt;
    logic [3:0]  attempt_cnt;
    logic [31:0] id_cap, ts_cap;
    logic        pending;
    logic        finish;
    logic        done_q;
    logic        read_end, id_hit, ts_hit;
    result_t     result;

    assign read_end = (wait_cnt == WAIT_LAST);
    assign id_hit   = (id_cap == EXPECTED_ID);
    assign ts_hit   = (ts_cap == EXPECTED_TS);

    always_comb begin
        state_nxt = state;
        finish    = 1'b0;
        case (state)
            IDLE:  if (bus.start || pending) state_nxt = RD_ID;
            RD_ID: if (read_end) state_nxt = RD_TS;
            RD_TS: if (read_end) state_nxt = CMP;
            CMP: begin
                if ((id_hit && ts_hit) || (attempt_cnt == LAST_ATTEMPT)) begin
                    state_nxt = IDLE;
                    finish    = 1'b1;
                end else begin
                    state_nxt = RD_ID;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pending     <= AUTO_START;
            wait_cnt    <= '0;
            attempt_cnt <= '0;
            id_cap      <= '0;
            ts_cap      <= '0;
            done_q      <= 1'b0;
            result      <= '0;
        end else begin
            state  <= state_nxt;
            done_q <= finish;
            // Wait counter restarts on every state change so each read window is L+1 cycles.
            if (state_nxt != state || state == IDLE || state == CMP)
                wait_cnt <= '0;
            else
                wait_cnt <= wait_cnt + 3'd1;
            if (state == IDLE && state_nxt == RD_ID) begin
                pending     <= 1'b0;
                attempt_cnt <= 4'd1;
            end
            if (state == CMP && state_nxt == RD_ID)
                attempt_cnt <= attempt_cnt + 4'd1;
            if (state == RD_ID && read_end)
                id_cap <= bus.sys_readdata;
            if (state == RD_TS && read_end)
                ts_cap <= bus.sys_readdata;
            if (finish)
                result <= '{match: id_hit && ts_hit, id_ok: id_hit, ts_ok: ts_hit,
                            id_value: id_cap, ts_value: ts_cap, attempts: attempt_cnt};
        end
    end

    // Address is decoded from the state register, so it only moves on transition edges.
    assign bus.sys_address = (state == RD_TS);
    assign bus.busy        = (state != IDLE);
    assign bus.done        = done_q;
    assign bus.match       = result.match;
    assign bus.id_ok       = result.id_ok;
    assign bus.ts_ok       = result.ts_ok;
    assign bus.id_value    = result.id_value;
    assign bus.ts_value    = result.ts_value;
    assign bus.attempts    = result.attempts;
endmodule

// File: tb/tb_sysid_checker.sv
// Checks three sysid_checker configurations against a timeline model of the check.
module tb_sysid_checker;
    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1516688433;
    localparam int NI   = 3;
    localparam int LOGN = 4096;
    localparam int LAT  [NI] = '{1, 0, 7};
    localparam int RMAX [NI] = '{3, 1, 2};
    localparam bit AUTO [NI] = '{1'b1, 1'b0, 1'b0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sysid_checker_if bus0 ();
    sysid_checker_if bus1 ();
    sysid_checker_if bus2 ();

    logic [31:0] id_src [NI];
    logic [31:0] ts_src [NI];
    logic        start_src [NI];
    logic [73:0] dut_vec [NI];

    // Slave model: word selected by the DUT's address.
    assign bus0.start        = start_src[0];
    assign bus1.start        = start_src[1];
    assign bus2.start        = start_src[2];
    assign bus0.sys_readdata = bus0.sys_address ? ts_src[0] : id_src[0];
    assign bus1.sys_readdata = bus1.sys_address ? ts_src[1] : id_src[1];
    assign bus2.sys_readdata = bus2.sys_address ? ts_src[2] : id_src[2];

    assign dut_vec[0] = {bus0.sys_address, bus0.busy, bus0.done, bus0.match, bus0.id_ok, bus0.ts_ok,
                         bus0.id_value, bus0.ts_value, bus0.attempts};
    assign dut_vec[1] = {bus1.sys_address, bus1.busy, bus1.done, bus1.match, bus1.id_ok, bus1.ts_ok,
                         bus1.id_value, bus1.ts_value, bus1.attempts};
    assign dut_vec[2] = {bus2.sys_address, bus2.busy, bus2.done, bus2.match, bus2.id_ok, bus2.ts_ok,
                         bus2.id_value, bus2.ts_value, bus2.attempts};

    sysid_checker #(.READ_LATENCY(1), .RETRY_MAX(3), .AUTO_START(1'b1))
        u0 (.clock(clk), .reset(rst), .bus(bus0));
    sysid_checker #(.READ_LATENCY(0), .RETRY_MAX(1), .AUTO_START(1'b0))
        u1 (.clock(clk), .reset(rst), .bus(bus1));
    sysid_checker #(.READ_LATENCY(7), .RETRY_MAX(2), .AUTO_START(1'b0))
        u2 (.clock(clk), .reset(rst), .bus(bus2));

    // Input history, indexed by the rising edge that samples it.
    logic [31:0] id_log [NI][LOGN];
    logic [31:0] ts_log [NI][LOGN];
    bit          st_log [NI][LOGN];

    // Model: a check started at edge e0 has attempt k reading the ID at
    // e0+(k-1)P+L+1 and the timestamp at e0+(k-1)P+2L+2, deciding at e0+kP.
    int          cyc = 0;
    bit          m_act [NI], m_pend [NI], m_done [NI];
    bit          m_match [NI], m_idok [NI], m_tsok [NI];
    logic [31:0] m_idv [NI], m_tsv [NI];
    logic [3:0]  m_att [NI];
    int          m_e0 [NI];

    task automatic model_step(input int i);
        bit was, idg, tsg;
        int p, rel, a;
        logic [31:0] idw, tsw;
        p = 2 * LAT[i] + 3;
        m_done[i] = 1'b0;
        was = m_act[i];
        if (m_act[i]) begin
            rel = cyc - m_e0[i];
            if (rel % p == 0) begin
                a   = rel / p;
                idw = id_log[i][m_e0[i] + (a - 1) * p + LAT[i] + 1];
                tsw = ts_log[i][m_e0[i] + (a - 1) * p + 2 * LAT[i] + 2];
                idg = (idw == EXP_ID);
                tsg = (tsw == EXP_TS);
                if ((idg && tsg) || a == RMAX[i] + 1) begin
                    m_act[i]   = 1'b0;
                    m_done[i]  = 1'b1;
                    m_match[i] = idg && tsg;
                    m_idok[i]  = idg;
                    m_tsok[i]  = tsg;
                    m_idv[i]   = idw;
                    m_tsv[i]   = tsw;
                    m_att[i]   = 4'(a);
                end
            end
        end
        if (!was && (st_log[i][cyc] || m_pend[i])) begin
            m_act[i]  = 1'b1;
            m_e0[i]   = cyc;
            m_pend[i] = 1'b0;
        end
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                m_act[i] = 1'b0; m_pend[i] = AUTO[i]; m_done[i] = 1'b0;
                m_match[i] = 1'b0; m_idok[i] = 1'b0; m_tsok[i] = 1'b0;
                m_idv[i] = '0; m_tsv[i] = '0; m_att[i] = '0;
            end else begin
                model_step(i);
            end
        end
    end

    function automatic logic [73:0] model_vec(input int i);
        int p, ph;
        bit addr;
        p    = 2 * LAT[i] + 3;
        addr = 1'b0;
        if (m_act[i]) begin
            ph   = (cyc - m_e0[i]) % p;
            addr = (ph >= LAT[i] + 1) && (ph <= 2 * LAT[i] + 1);
        end
        return {addr, m_act[i], m_done[i], m_match[i], m_idok[i], m_tsok[i], m_idv[i], m_tsv[i], m_att[i]};
    endfunction

    int n_tests = 0, n_fail = 0;
    int done_cnt [NI], addr_cnt [NI], busy_cnt [NI], done_edge [NI];
    int snap_done [NI], snap_addr [NI], snap_busy [NI];

    task automatic check_vec(input string name, input int i, input logic [73:0] act, input logic [73:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s u%0d edge=%0d: got %h expected %h", name, i, cyc, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int i, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s u%0d: got %0d expected %0d", name, i, act, exp);
        end
    endtask

    task automatic compare_all();
        logic [73:0] e;
        for (int i = 0; i < NI; i++) begin
            e = rst ? 74'd0 : model_vec(i);
            check_vec("cycle", i, dut_vec[i], e);
            if (dut_vec[i][71]) begin done_cnt[i]++; done_edge[i] = cyc; end
            if (dut_vec[i][73]) addr_cnt[i]++;
            if (dut_vec[i][72]) busy_cnt[i]++;
        end
    endtask

    task automatic log_inputs();
        for (int i = 0; i < NI; i++) begin
            id_log[i][cyc + 1] = id_src[i];
            ts_log[i][cyc + 1] = ts_src[i];
            st_log[i][cyc + 1] = start_src[i];
        end
    endtask

    task automatic step();
        log_inputs();
        @(negedge clk);
        compare_all();
    endtask

    task automatic mark();
        for (int i = 0; i < NI; i++) begin
            snap_done[i] = done_cnt[i];
            snap_addr[i] = addr_cnt[i];
            snap_busy[i] = busy_cnt[i];
        end
    endtask

    // Pulse reset; returns at the negedge where it is released, with e0 = next edge.
    task automatic reset_pulse(output int e0);
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        e0 = cyc + 1;
    endtask

    function automatic logic [31:0] rand_word(input logic [31:0] good);
        if ($urandom_range(0, 3) != 0) return good;
        if ($urandom_range(0, 1) == 0) return $urandom;
        return good ^ (32'd1 << $urandom_range(0, 31));
    endfunction

    int e0, s0;
    logic [31:0] bad_id;

    initial begin
        for (int i = 0; i < NI; i++) begin
            id_src[i] = EXP_ID; ts_src[i] = EXP_TS; start_src[i] = 1'b0;
            done_cnt[i] = 0; addr_cnt[i] = 0; busy_cnt[i] = 0; done_edge[i] = 0;
        end
        bad_id = 32'hDEADBEEF;

        // Auto-start pass with L=1: done 5 edges after E0.
        repeat (3) step();
        mark();
        rst = 1'b0;
        e0 = cyc + 1;
        repeat (8) step();
        check_int("auto_done_count", 0, done_cnt[0] - snap_done[0], 1);
        check_int("auto_done_edge", 0, done_edge[0] - e0, 5);
        check_int("auto_busy_cycles", 0, busy_cnt[0] - snap_busy[0], 5);
        check_int("auto_addr_cycles", 0, addr_cnt[0] - snap_addr[0], 2);
        check_vec("auto_result", 0, dut_vec[0], {3'b000, 3'b111, 32'd0, 32'd1516688433, 4'd1});

        // Timestamp off by one forever: four attempts then a single failing done.
        ts_src[0] = EXP_TS - 32'd1;
        mark();
        reset_pulse(e0);
        repeat (24) step();
        check_int("ts_bad_done_count", 0, done_cnt[0] - snap_done[0], 1);
        check_int("ts_bad_done_edge", 0, done_edge[0] - e0, 20);
        check_vec("ts_bad_result", 0, dut_vec[0], {3'b000, 3'b010, 32'd0, 32'd1516688432, 4'd4});

        // Bad ID on the first attempt only.
        ts_src[0] = EXP_TS;
        id_src[0] = bad_id;
        mark();
        reset_pulse(e0);
        repeat (3) step();
        id_src[0] = EXP_ID;
        repeat (10) step();
        check_int("id_retry_done_count", 0, done_cnt[0] - snap_done[0], 1);
        check_int("id_retry_done_edge", 0, done_edge[0] - e0, 10);
        check_vec("id_retry_result", 0, dut_vec[0], {3'b000, 3'b111, 32'd0, 32'd1516688433, 4'd2});

        // Manual start on L=0 and L=7 units, second start while busy is dropped.
        mark();
        start_src[1] = 1'b1; start_src[2] = 1'b1;
        s0 = cyc + 1;
        step();
        start_src[1] = 1'b0; start_src[2] = 1'b0;
        step();
        start_src[1] = 1'b1; start_src[2] = 1'b1;
        step();
        start_src[1] = 1'b0; start_src[2] = 1'b0;
        repeat (20) step();
        check_int("l0_done_count", 1, done_cnt[1] - snap_done[1], 1);
        check_int("l0_done_edge", 1, done_edge[1] - s0, 3);
        check_int("l0_addr_cycles", 1, addr_cnt[1] - snap_addr[1], 1);
        check_int("l7_done_count", 2, done_cnt[2] - snap_done[2], 1);
        check_int("l7_done_edge", 2, done_edge[2] - s0, 17);
        check_int("l7_addr_cycles", 2, addr_cnt[2] - snap_addr[2], 8);

        // Reset landing in RD_TS: outputs clear at once, no done, clean rerun.
        mark();
        reset_pulse(e0);
        repeat (3) step();
        log_inputs();
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_vec("async_reset_clear", 0, dut_vec[0], 74'd0);
        @(negedge clk);
        compare_all();
        step();
        rst = 1'b0;
        e0 = cyc + 1;
        repeat (8) step();
        check_int("rerun_done_count", 0, done_cnt[0] - snap_done[0], 1);
        check_int("rerun_done_edge", 0, done_edge[0] - e0, 5);
        check_vec("rerun_result", 0, dut_vec[0], {3'b000, 3'b111, 32'd0, 32'd1516688433, 4'd1});

        // Randomized data, starts and occasional resets against the model.
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < NI; i++) begin
                id_src[i]    = rand_word(EXP_ID);
                ts_src[i]    = rand_word(EXP_TS);
                start_src[i] = ($urandom_range(0, 9) == 0);
            end
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sysid_checker.md
# sysid_checker

Boot-time integrity checker placed directly upstream of the Qsys system-ID slave. It drives the slave's 1-bit address and samples its 32-bit readdata: word 0 is the system ID, word 1 is the generation timestamp. It compares both words against build-time expectations and reports the result as a registered pass/fail with a one-cycle done pulse. Mismatches are retried a bounded number of times before failure is reported. The result feeds the CPU-side status/LED logic.

## Interface
- EXPECTED_ID, 32'd0: expected system ID (word 0).
- EXPECTED_TS, 32'd1516688433: expected timestamp (word 1).
- READ_LATENCY, 1: wait cycles between driving the address and sampling readdata; legal range 0..7.
- RETRY_MAX, 3: extra attempts after the first failing attempt; legal range 0..14.
- AUTO_START, 1: if 1, a check runs automatically after reset release.
- clock  input  1  system clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a check; sampled only in IDLE.
- sys_address  output  1  address to the sysid slave.
- sys_readdata  input  32  readdata from the sysid slave.
- busy  output  1  high while a check is in progress.
- done  output  1  one-cycle pulse when a check completes.
- match  output  1  ID and timestamp both matched on the final attempt.
- id_ok  output  1  ID matched on the final attempt.
- ts_ok  output  1  timestamp matched on the final attempt.
- id_value  output  32  ID captured on the final attempt.
- ts_value  output  32  timestamp captured on the final attempt.
- attempts  output  4  number of attempts used by the last check (1..RETRY_MAX+1).

## Operation
- States:
  - IDLE
  - RD_ID: sys_address=0
  - RD_TS: sys_address=1
  - CMP
- Each read state lasts READ_LATENCY+1 cycles. A wait counter counts 0..READ_LATENCY, and sys_readdata is captured into an internal register on the edge that leaves the state.
- Transitions:
  - IDLE → RD_ID when start=1 or when the auto-start pending flag is set.
  - RD_ID → RD_TS.
  - RD_TS → CMP.
  - CMP → IDLE when both words match, or when the attempt count equals RETRY_MAX+1.
  - CMP → RD_ID otherwise, with the attempt count incremented.
- On the edge that leaves CMP for IDLE, in the same cycle:
  - match, id_ok, ts_ok, id_value, ts_value and attempts are updated.
  - done is asserted for exactly one cycle.
  - busy is deasserted.
- Result outputs hold their values until the next completion or until reset.
- busy=1 in every state except IDLE.
- start while busy is ignored; there is no queuing.
- If start is still high in the cycle after done, a new check begins on that edge (back-to-back runs).
- Auto-start:
  - Reset sets the pending flag when AUTO_START=1.
  - The flag clears on the IDLE→RD_ID edge.
  - An external start in the same cycle is merged, not counted twice.
- The comparison is a full 32-bit equality; no masking.
- The attempt counter is 4 bits, and RETRY_MAX ≤ 14 guarantees it never wraps.

## Timing
- Reset values: sys_address=0, busy=0, done=0, match=0, id_ok=0, ts_ok=0, id_value=0, ts_value=0, attempts=0. State is IDLE. The pending flag is set to AUTO_START.
- Reset takes effect asynchronously, with outputs forced to the values above immediately. Release takes effect on the next rising edge.
- Edge numbering: let edge E0 be the edge at which IDLE accepts the start, so E0 leaves IDLE.
  - ID is captured at E(L+1), where L = READ_LATENCY.
  - Timestamp is captured at E(2L+2).
  - CMP is decided at E(2L+3).
  - Per-attempt period: 2L+3 cycles.
- Passing run, first attempt: done is high in the cycle after E(2L+3). With L=1 this is 5 edges after E0.
- With N attempts, done is high after E(N·(2L+3)).
- With AUTO_START=1, E0 is the first rising edge after reset deasserts.
- sys_address changes only on state-transition edges, and it is stable for the full read window.
- Reset asserted mid-check aborts the check with no done pulse. If AUTO_START=1, a fresh check begins at the first edge after release.

## Test plan
- Defaults, slave model returns 0 / 1516688433, L=1 → done at edge 5 after reset release; match=1, id_ok=1, ts_ok=1, attempts=1, busy high for edges 1..5 only.
- Slave returns timestamp 1516688432 permanently → exactly one done, after 4 attempts (edge 20); match=0, id_ok=1, ts_ok=0, ts_value=1516688432, attempts=4.
- Slave returns ID 0xDEADBEEF on attempt 1 only, correct thereafter → match=1, attempts=2, done after edge 10.
- AUTO_START=0, start pulsed at cycle 3, then again 2 cycles later while busy → exactly one done pulse; the second start is ignored.
- Reset asserted during RD_TS → all outputs 0 immediately with no done pulse; after release the check reruns and passes at edge 5.
- READ_LATENCY=0 and READ_LATENCY=7 → done at edge 3 and edge 17 respectively; sys_address=1 holds for exactly 1 and 8 cycles.
